// File: rtl/l2_cache.sv
// Unified 2-way set-associative write-back L2 cache, one word per line, 1-bit LRU per set.
// Optional hit/miss/writeback counters are compiled in with `define L2_STATS_EN.
module l2_cache #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CACHE_SIZE = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] l1_addr,
  input  logic [DATA_WIDTH-1:0] l1_data_in,
  output logic [DATA_WIDTH-1:0] l1_data_out,
  input  logic                  l1_read,
  input  logic                  l1_write,
  output logic                  l1_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready
`ifdef L2_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_writebacks
`endif
);

  localparam int unsigned NUM_SETS = CACHE_SIZE / 8;
  localparam int unsigned IDX_W    = $clog2(NUM_SETS);
  localparam int unsigned WORD_W   = ADDR_WIDTH - 2;
  localparam int unsigned TAG_W    = WORD_W - IDX_W;

  typedef enum logic [2:0] {StIdle, StLookup, StWriteback, StFill, StRespond} state_e;

  state_e state_q, state_d;

  logic [WORD_W-1:0]     req_word_q, req_word_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic                  req_write_q, req_write_d;
  logic                  victim_q, victim_d;
  logic [DATA_WIDTH-1:0] l1_data_out_q, l1_data_out_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_out_q, mem_data_out_d;

  logic [1:0][NUM_SETS-1:0] valid_q;
  logic [1:0][NUM_SETS-1:0] dirty_q;
  logic [NUM_SETS-1:0]      lru_q;
  logic [TAG_W-1:0]         tag_q  [2][NUM_SETS];
  logic [DATA_WIDTH-1:0]    data_q [2][NUM_SETS];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  hit0, hit1, hit_any, hit_way, victim_way;
  logic                  line_we, line_way, line_dirty;
  logic [DATA_WIDTH-1:0] line_data;
  logic                  lru_we, lru_way, dirty_clr;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^l1_addr[1:0];

  assign req_idx = req_word_q[IDX_W-1:0];
  assign req_tag = req_word_q[WORD_W-1:IDX_W];

  assign hit0    = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1    = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit_any = hit0 || hit1;
  assign hit_way = hit1;

  // Fill empty ways in order before evicting the LRU way.
  assign victim_way = !valid_q[0][req_idx] ? 1'b0 :
                      !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];

  always_comb begin
    state_d        = state_q;
    req_word_d     = req_word_q;
    req_data_d     = req_data_q;
    req_write_d    = req_write_q;
    victim_d       = victim_q;
    l1_data_out_d  = l1_data_out_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    line_we        = 1'b0;
    line_way       = victim_q;
    line_data      = req_data_q;
    line_dirty     = 1'b1;
    lru_we         = 1'b0;
    lru_way        = victim_q;
    dirty_clr      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (l1_read || l1_write) begin
          req_word_d  = l1_addr[ADDR_WIDTH-1:2];
          req_data_d  = l1_data_in;
          req_write_d = l1_write;
          state_d     = StLookup;
        end
      end
      StLookup: begin
        if (hit_any) begin
          lru_we  = 1'b1;
          lru_way = hit_way;
          if (req_write_q) begin
            line_we  = 1'b1;
            line_way = hit_way;
          end else begin
            l1_data_out_d = data_q[hit_way][req_idx];
          end
          state_d = StRespond;
        end else begin
          victim_d = victim_way;
          if (valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx]) begin
            mem_addr_d     = {tag_q[victim_way][req_idx], req_idx, 2'b00};
            mem_data_out_d = data_q[victim_way][req_idx];
            state_d        = StWriteback;
          end else if (req_write_q) begin
            // Line is one word, so a write miss installs without fetching.
            line_we  = 1'b1;
            line_way = victim_way;
            lru_we   = 1'b1;
            lru_way  = victim_way;
            state_d  = StRespond;
          end else begin
            mem_addr_d = {req_word_q, 2'b00};
            state_d    = StFill;
          end
        end
      end
      StWriteback: begin
        if (mem_ready) begin
          if (req_write_q) begin
            line_we = 1'b1;
            lru_we  = 1'b1;
            state_d = StRespond;
          end else begin
            dirty_clr  = 1'b1;
            mem_addr_d = {req_word_q, 2'b00};
            state_d    = StFill;
          end
        end
      end
      StFill: begin
        if (mem_ready) begin
          line_we       = 1'b1;
          line_data     = mem_data_in;
          line_dirty    = 1'b0;
          lru_we        = 1'b1;
          l1_data_out_d = mem_data_in;
          state_d       = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      req_word_q     <= '0;
      req_data_q     <= '0;
      req_write_q    <= 1'b0;
      victim_q       <= 1'b0;
      l1_data_out_q  <= '0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      lru_q          <= '0;
    end else begin
      state_q        <= state_d;
      req_word_q     <= req_word_d;
      req_data_q     <= req_data_d;
      req_write_q    <= req_write_d;
      victim_q       <= victim_d;
      l1_data_out_q  <= l1_data_out_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      if (line_we) begin
        valid_q[line_way][req_idx] <= 1'b1;
        dirty_q[line_way][req_idx] <= line_dirty;
      end else if (dirty_clr) begin
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
      if (lru_we) begin
        lru_q[req_idx] <= ~lru_way;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_way][req_idx]  <= req_tag;
      data_q[line_way][req_idx] <= line_data;
    end
  end

  assign l1_ready     = (state_q == StRespond);
  assign mem_read     = (state_q == StFill);
  assign mem_write    = (state_q == StWriteback);
  assign l1_data_out  = l1_data_out_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;

`ifdef L2_STATS_EN
  logic [31:0] stat_hits_q, stat_misses_q, stat_wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
      stat_wb_q     <= '0;
    end else begin
      if (state_q == StLookup && hit_any && stat_hits_q != '1) begin
        stat_hits_q <= stat_hits_q + 32'd1;
      end
      if (state_q == StLookup && !hit_any && stat_misses_q != '1) begin
        stat_misses_q <= stat_misses_q + 32'd1;
      end
      if (state_q == StWriteback && mem_ready && stat_wb_q != '1) begin
        stat_wb_q <= stat_wb_q + 32'd1;
      end
    end
  end

  assign stat_hits       = stat_hits_q;
  assign stat_misses     = stat_misses_q;
  assign stat_writebacks = stat_wb_q;
`endif

endmodule

// File: tb/tb_l2_cache.sv
// Directed self-checking bench for l2_cache with a simple latency-programmable memory model.
module tb_l2_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] l1_addr = '0;
  logic [31:0] l1_data_in = '0;
  logic [31:0] l1_data_out;
  logic        l1_read = 1'b0;
  logic        l1_write = 1'b0;
  logic        l1_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in = '0;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;
`ifdef L2_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  int tests = 0;
  int failed = 0;

  l2_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l1_addr      (l1_addr),
    .l1_data_in   (l1_data_in),
    .l1_data_out  (l1_data_out),
    .l1_read      (l1_read),
    .l1_write     (l1_write),
    .l1_ready     (l1_ready),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_ready    (mem_ready)
`ifdef L2_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: responds after mem_lat cycles of a held request.
  logic [31:0] mem_model [logic [31:0]];
  int          mem_lat = 3;
  int          busy_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_high = 0;
  int          unstable = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] held_addr = '0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (!rst_n) begin
      busy_cnt = 0;
    end else if (mem_read || mem_write) begin
      if (mem_read && mem_write) both_high++;
      if (busy_cnt == 0) held_addr = mem_addr;
      else if (mem_addr !== held_addr) unstable++;
      busy_cnt++;
      if (busy_cnt >= mem_lat) begin
        mem_ready = 1'b1;
        busy_cnt  = 0;
        if (mem_write) begin
          wr_cnt++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_data_out;
          mem_model[mem_addr] = mem_data_out;
        end else begin
          rd_cnt++;
          last_rd_addr = mem_addr;
          mem_data_in  = mem_val(mem_addr);
        end
      end
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the cache idle; returns cycles from sampling edge to l1_ready.
  task automatic l1_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat);
    l1_addr    = addr;
    l1_data_in = wdata;
    l1_read    = !wr;
    l1_write   = wr;
    lat        = 0;
    @(posedge clk);
    do begin
      @(negedge clk);
      lat++;
    end while (!l1_ready && lat < 200);
    l1_read  = 1'b0;
    l1_write = 1'b0;
    check("ready_timeout", 32'(lat < 200), 32'd1);
    @(negedge clk);
    check("ready_one_pulse", 32'(l1_ready), 32'd0);
  endtask

  int lat;
  int rd0, wr0;

  initial begin
    mem_model[32'h0000_0100] = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    check("rst_l1_ready", 32'(l1_ready), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_l1_data_out", l1_data_out, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data_out", mem_data_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean read miss then hit.
    l1_req(1'b0, 32'h0000_0100, '0, lat);
    check("miss_latency", 32'(lat), 32'd5);
    check("miss_data", l1_data_out, 32'hDEAD_BEEF);
    check("miss_rd_addr", last_rd_addr, 32'h0000_0100);
    check("miss_rd_cnt", 32'(rd_cnt), 32'd1);
    l1_req(1'b0, 32'h0000_0100, '0, lat);
    check("hit_latency", 32'(lat), 32'd2);
    check("hit_data", l1_data_out, 32'hDEAD_BEEF);
    check("hit_no_mem", 32'(rd_cnt), 32'd1);

    // Write hit leaves read data alone; following read sees the new word.
    l1_req(1'b1, 32'h0000_0100, 32'h1234_5678, lat);
    check("wr_hit_latency", 32'(lat), 32'd2);
    check("wr_keeps_dout", l1_data_out, 32'hDEAD_BEEF);
    l1_req(1'b0, 32'h0000_0102, '0, lat);
    check("rd_after_wr_lat", 32'(lat), 32'd2);
    check("rd_after_wr_data", l1_data_out, 32'h1234_5678);
    check("wr_hit_no_wb", 32'(wr_cnt), 32'd0);

    // Set 0: fill both ways, dirty way 0, touch way 1, then evict way 0.
    l1_req(1'b0, 32'h0000_0000, '0, lat);
    check("set0_w0_data", l1_data_out, 32'h5A5A_0000);
    l1_req(1'b0, 32'h0000_0800, '0, lat);
    check("set0_w1_lat", 32'(lat), 32'd5);
    check("set0_w1_data", l1_data_out, 32'h5A5A_0800);
    l1_req(1'b1, 32'h0000_0000, 32'hCAFE_0001, lat);
    check("set0_dirty_lat", 32'(lat), 32'd2);
    l1_req(1'b0, 32'h0000_0800, '0, lat);
    check("set0_touch_w1", 32'(lat), 32'd2);
    rd0 = rd_cnt;
    l1_req(1'b0, 32'h0000_1000, '0, lat);
    check("evict_latency", 32'(lat), 32'd8);
    check("evict_wr_cnt", 32'(wr_cnt), 32'd1);
    check("evict_wr_addr", last_wr_addr, 32'h0000_0000);
    check("evict_wr_data", last_wr_data, 32'hCAFE_0001);
    check("evict_rd_addr", last_rd_addr, 32'h0000_1000);
    check("evict_rd_cnt", 32'(rd_cnt), 32'(rd0 + 1));
    check("evict_data", l1_data_out, 32'h5A5A_1000);
    l1_req(1'b0, 32'h0000_0800, '0, lat);
    check("way1_untouched_lat", 32'(lat), 32'd2);
    check("way1_untouched_data", l1_data_out, 32'h5A5A_0800);
    // Way 0 holds 0x1000 clean now; re-reading 0x0000 fetches the written-back word.
    l1_req(1'b0, 32'h0000_0000, '0, lat);
    check("refetch_lat", 32'(lat), 32'd5);
    check("refetch_data", l1_data_out, 32'hCAFE_0001);
    check("refetch_no_wb", 32'(wr_cnt), 32'd1);

    // Write miss to a clean set installs directly.
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    l1_req(1'b1, 32'h0000_0204, 32'hA5A5_A5A5, lat);
    check("wr_miss_lat", 32'(lat), 32'd2);
    check("wr_miss_no_rd", 32'(rd_cnt), 32'(rd0));
    check("wr_miss_no_wr", 32'(wr_cnt), 32'(wr0));
    l1_req(1'b0, 32'h0000_0204, '0, lat);
    check("wr_miss_read_lat", 32'(lat), 32'd2);
    check("wr_miss_read_data", l1_data_out, 32'hA5A5_A5A5);

    // Reset while a fill is outstanding.
    mem_lat  = 1000;
    l1_addr  = 32'h0000_0300;
    l1_read  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    l1_read = 1'b0;
    repeat (2) @(negedge clk);
    check("fill_mem_read", 32'(mem_read), 32'd1);
    check("fill_mem_addr", mem_addr, 32'h0000_0300);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mem_read", 32'(mem_read), 32'd0);
    check("async_rst_mem_addr", mem_addr, 32'h0);
    check("async_rst_dout", l1_data_out, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_lat = 3;
    @(negedge clk);
    rd0 = rd_cnt;
    l1_req(1'b0, 32'h0000_0100, '0, lat);
    check("post_rst_miss_lat", 32'(lat), 32'd5);
    check("post_rst_rd_cnt", 32'(rd_cnt), 32'(rd0 + 1));
    check("post_rst_data", l1_data_out, 32'hDEAD_BEEF);

    check("mem_rd_wr_exclusive", 32'(both_high), 32'd0);
    check("mem_addr_stable", 32'(unstable), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l2_cache.md
Name: l2_cache

Overview:
- Unified second-level cache directly downstream of the L1 cache; services L1 miss/writeback requests and talks to main memory.
- 2-way set-associative, write-back, write-allocate, one 32-bit word per line, 1-bit LRU per set.
- Single outstanding request on each side; a blocking FSM serialises lookup, victim writeback and fill.

Parameters:
- DATA_WIDTH, 32, word width (fixed 32; byte offset = 2 bits)
- ADDR_WIDTH, 32, byte address width
- CACHE_SIZE, 4096, total data capacity in bytes
- NUM_SETS (localparam), CACHE_SIZE/8, sets for 2 ways x 4 bytes (512 by default; index = log2(NUM_SETS) bits; tag = ADDR_WIDTH-2-index bits)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- l1_addr  in  ADDR_WIDTH  request byte address from L1 (bits [1:0] ignored)
- l1_data_in  in  DATA_WIDTH  write data from L1
- l1_data_out  out  DATA_WIDTH  read data to L1
- l1_read  in  1  read request, held until l1_ready
- l1_write  in  1  write request, held until l1_ready
- l1_ready  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_WIDTH  memory word address (low 2 bits 0)
- mem_data_out  out  DATA_WIDTH  writeback data to memory
- mem_data_in  in  DATA_WIDTH  fill data from memory
- mem_read  out  1  fill request, held until mem_ready
- mem_write  out  1  writeback request, held until mem_ready
- mem_ready  in  1  memory completion pulse; data valid same cycle

Behaviour:
- Reset (async, any state): FSM to IDLE; all valid, dirty and LRU bits cleared; l1_ready, mem_read, mem_write = 0; l1_data_out, mem_addr, mem_data_out = 0. Data/tag arrays need no reset. An in-flight memory transaction is abandoned.
- States: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
- IDLE: when l1_read or l1_write is high, register addr, data and op, then go to LOOKUP. If both are high, treat as write.
- LOOKUP: compare tag against both ways of the indexed set.
  - Read hit: l1_data_out <= hit data; go to RESPOND.
  - Write hit: write the word; set dirty; go to RESPOND.
  - Miss: pick the victim. Use invalid way 0 first, then invalid way 1, else the way named by LRU.
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: read miss goes to FILL; write miss installs the word directly (valid=1, dirty=1, tag updated, no fill since line = 1 word) and goes to RESPOND.
- WRITEBACK: mem_write=1, mem_addr={victim tag, index, 2'b00}, mem_data_out=victim data, all held stable. On mem_ready: drop mem_write, clear victim dirty. Then a read goes to FILL; a write installs as above and goes to RESPOND.
- FILL: mem_read=1, mem_addr={req tag, index, 2'b00}, held stable. On mem_ready: write mem_data_in to the victim way (valid=1, dirty=0, new tag), l1_data_out <= mem_data_in, drop mem_read, go to RESPOND.
- RESPOND: l1_ready=1 for exactly one cycle; go to IDLE.
- LRU: on every hit or install, LRU[set] <= the other way.
- Latency, counted from the edge that samples the request in IDLE:
  - Hit: l1_ready high 2 cycles later.
  - Clean miss: 2 cycles plus memory latency.
  - Dirty read miss: adds a writeback round trip.
- L1 must drop l1_read/l1_write on the edge where it sees l1_ready. The next IDLE cycle re-samples, so back-to-back requests cost no idle gap beyond IDLE.
- l1_data_out holds its last read value until the next read completes; writes do not change it.
- mem_ready outside WRITEBACK/FILL is ignored.
- mem_read and mem_write are never high together.
- Request inputs changing mid-transaction are ignored (they are registered).

Optional Feature:
- Macro L2_STATS_EN.
- Defined: adds outputs stat_hits, stat_misses, stat_writebacks, each 32 bits, saturating at all-ones and reset to 0.
  - Hits and misses increment in LOOKUP.
  - Writebacks increment on mem_ready in WRITEBACK.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, read 0x0000_0100, memory returns 0xDEADBEEF after 3 cycles -> mem_read addr 0x100; l1_data_out=0xDEADBEEF; l1_ready one pulse.
- Repeat read 0x100 -> no memory activity; l1_ready exactly 2 cycles after request sampled; data 0xDEADBEEF.
- Write 0x100=0x12345678, then read 0x100 -> hit both times, read returns 0x12345678; no mem_write.
- Fill both ways of set 0 (0x0000, 0x0800 for default sizes), dirty way 0, access way 1, then read 0x1000 -> mem_write addr 0x0000 with dirty data, then mem_read 0x1000; way 1 untouched.
- Write miss to clean set, address 0x204 = 0xA5A5A5A5 -> no mem_read/mem_write; a later read returns 0xA5A5A5A5.
- Assert rst_n low during FILL while mem_read high -> mem_read drops asynchronously; after release, read of the prior address misses again.
